// File: rtl/evm_pkg.sv
// Shared definitions for the electronic voting machine blocks.
//   vote_state_t            : ballot FSM states (IDLE, WAIT_RELEASE, LOCKOUT)
//   DEFAULT_HOLD_CYCLES     : default debounce qualification time in clocks
//   DEFAULT_LOCKOUT_CYCLES  : default post-vote dead time in clocks
package evm_pkg;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      WAIT_RELEASE = 2'd1,
      LOCKOUT      = 2'd2
   } vote_state_t;

   localparam int DEFAULT_HOLD_CYCLES    = 10_000_000;
   localparam int DEFAULT_LOCKOUT_CYCLES = 50_000_000;

endpackage

// File: rtl/button_debounce_ch.sv
// One candidate button channel: 2-flop synchroniser followed by a saturating
// hold counter.
//   clock   in   system clock
//   reset   in   asynchronous active-high reset
//   button  in   raw asynchronous button, active-high
//   s       out  synchronised button level
//   qual    out  high for one cycle when the press has been held long enough
module button_debounce_ch
   import evm_pkg::*;
#(
   parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES
) (
   input  logic clock,
   input  logic reset,
   input  logic button,
   output logic s,
   output logic qual
);

   localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

   logic [1:0]       sync_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W-1:0] cnt_next;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync_reg <= 2'b00;
         cnt_reg  <= '0;
      end else begin
         sync_reg <= {sync_reg[0], button};
         cnt_reg  <= cnt_next;
      end
   end

   // Counter saturates at HOLD_CYCLES so a long press never re-qualifies.
   always_comb begin
      cnt_next = cnt_reg;
      if (!sync_reg[1]) begin
         cnt_next = '0;
      end else if (cnt_reg < CNT_W'(HOLD_CYCLES)) begin
         cnt_next = cnt_reg + CNT_W'(1);
      end
   end

   assign s    = sync_reg[1];
   // Qualifies on the single cycle the count passes HOLD_CYCLES-1.
   assign qual = sync_reg[1] & (cnt_reg == CNT_W'(HOLD_CYCLES - 1));

endmodule

// File: rtl/vote_button_bank.sv
// Multi-channel vote qualifier: debounces NUM_CH candidate buttons, accepts at
// most one vote per press, rejects simultaneous presses and enforces a
// release-then-lockout interval before the next vote.
//   clock          in   system clock
//   reset          in   asynchronous active-high reset
//   enable         in   ballot enabled by the control unit
//   button         in   raw candidate buttons [NUM_CH-1:0], active-high
//   vote_valid     out  one-cycle pulse: vote accepted
//   vote_index     out  candidate index, holds last value between votes
//   vote_conflict  out  one-cycle pulse: press rejected, >1 button held
//   busy           out  high when not IDLE or when enable is low
module vote_button_bank
   import evm_pkg::*;
#(
   parameter int NUM_CH         = 4,
   parameter int HOLD_CYCLES    = DEFAULT_HOLD_CYCLES,
   parameter int LOCKOUT_CYCLES = DEFAULT_LOCKOUT_CYCLES,
   localparam int IDX_W         = $clog2(NUM_CH)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              enable,
   input  logic [NUM_CH-1:0] button,
   output logic              vote_valid,
   output logic [IDX_W-1:0]  vote_index,
   output logic              vote_conflict,
   output logic              busy
);

   // Extra bit keeps the width legal when LOCKOUT_CYCLES is 1.
   localparam int LOCK_W = $clog2(LOCKOUT_CYCLES + 1);

   logic [NUM_CH-1:0] s_vec;
   logic [NUM_CH-1:0] qual_vec;

   vote_state_t       state_reg, state_next;
   logic [LOCK_W-1:0] lock_cnt_reg, lock_cnt_next;
   logic              vote_valid_reg, vote_valid_next;
   logic              vote_conflict_reg, vote_conflict_next;
   logic [IDX_W-1:0]  vote_index_reg, vote_index_next;

   logic [IDX_W-1:0]  hot_idx;
   logic              any_hot;
   logic              multi_hot;

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      button_debounce_ch #(
         .HOLD_CYCLES (HOLD_CYCLES)
      ) u_ch (
         .clock  (clock),
         .reset  (reset),
         .button (button[gi]),
         .s      (s_vec[gi]),
         .qual   (qual_vec[gi])
      );
   end

   // Index encoder and "more than one held" detector over the synchronised
   // levels; the level, not qual, decides conflict so a second button that
   // is still debouncing also blocks the vote.
   always_comb begin
      hot_idx   = '0;
      any_hot   = 1'b0;
      multi_hot = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (s_vec[i]) begin
            if (any_hot) multi_hot = 1'b1;
            any_hot = 1'b1;
            hot_idx = IDX_W'(i);
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg         <= IDLE;
         lock_cnt_reg      <= '0;
         vote_valid_reg    <= 1'b0;
         vote_conflict_reg <= 1'b0;
         vote_index_reg    <= '0;
      end else begin
         state_reg         <= state_next;
         lock_cnt_reg      <= lock_cnt_next;
         vote_valid_reg    <= vote_valid_next;
         vote_conflict_reg <= vote_conflict_next;
         vote_index_reg    <= vote_index_next;
      end
   end

   always_comb begin
      state_next         = state_reg;
      lock_cnt_next      = lock_cnt_reg;
      vote_valid_next    = 1'b0;
      vote_conflict_next = 1'b0;
      vote_index_next    = vote_index_reg;
      case (state_reg)
         IDLE: begin
            if (enable && (|qual_vec)) begin
               if (multi_hot) begin
                  vote_conflict_next = 1'b1;
               end else begin
                  vote_valid_next = 1'b1;
                  vote_index_next = hot_idx;
               end
               state_next = WAIT_RELEASE;
            end
         end
         WAIT_RELEASE: begin
            if (!(|s_vec)) begin
               lock_cnt_next = LOCK_W'(LOCKOUT_CYCLES - 1);
               state_next    = LOCKOUT;
            end
         end
         LOCKOUT: begin
            // Qualifications arriving here are simply not looked at.
            if (lock_cnt_reg == '0) begin
               state_next = IDLE;
            end else begin
               lock_cnt_next = lock_cnt_reg - LOCK_W'(1);
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign vote_valid    = vote_valid_reg;
   assign vote_conflict = vote_conflict_reg;
   assign vote_index    = vote_index_reg;
   assign busy          = (state_reg != IDLE) | ~enable;

endmodule

// File: tb/tb_vote_button_bank.sv
// Directed self-checking bench for vote_button_bank.
// Main instance: NUM_CH=4, HOLD_CYCLES=4, LOCKOUT_CYCLES=3.
// A second instance with a longer lockout (10) is used for the discard case,
// since with a 3-cycle lockout a fresh press cannot qualify inside LOCKOUT.
module tb_vote_button_bank;

   logic       clock;
   logic       reset;
   logic       enable;
   logic [3:0] button;
   logic       vote_valid;
   logic [1:0] vote_index;
   logic       vote_conflict;
   logic       busy;

   logic [3:0] button_lk;
   logic       lk_valid;
   logic [1:0] lk_index;
   logic       lk_conflict;
   logic       lk_busy;

   int n_assert = 0;
   int n_fail   = 0;

   // per-window observation counters (cycle numbers relative to clear())
   int cyc, nv, fv, nc, fc, nboth, lkv, lkfv, lkc;
   int last_idx, lk_idx;

   vote_button_bank #(
      .NUM_CH         (4),
      .HOLD_CYCLES    (4),
      .LOCKOUT_CYCLES (3)
   ) u_dut (
      .clock         (clock),
      .reset         (reset),
      .enable        (enable),
      .button        (button),
      .vote_valid    (vote_valid),
      .vote_index    (vote_index),
      .vote_conflict (vote_conflict),
      .busy          (busy)
   );

   vote_button_bank #(
      .NUM_CH         (4),
      .HOLD_CYCLES    (4),
      .LOCKOUT_CYCLES (10)
   ) u_lk (
      .clock         (clock),
      .reset         (reset),
      .enable        (enable),
      .button        (button_lk),
      .vote_valid    (lk_valid),
      .vote_index    (lk_index),
      .vote_conflict (lk_conflict),
      .busy          (lk_busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic clear();
      cyc = 0; nv = 0; fv = 0; nc = 0; fc = 0;
      lkv = 0; lkfv = 0; lkc = 0;
   endtask

   // Advance n cycles, sampling outputs on each falling edge.
   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         cyc++;
         if (vote_valid) begin
            nv++;
            if (fv == 0) fv = cyc;
            last_idx = int'(vote_index);
         end
         if (vote_conflict) begin
            nc++;
            if (fc == 0) fc = cyc;
         end
         if (vote_valid && vote_conflict) nboth++;
         if (lk_valid) begin
            lkv++;
            if (lkfv == 0) lkfv = cyc;
            lk_idx = int'(lk_index);
         end
         if (lk_conflict) lkc++;
      end
   endtask

   initial begin
      reset = 1'b1; enable = 1'b0; button = '0; button_lk = '0;
      nboth = 0; last_idx = -1; lk_idx = -1;
      clear();
      run(2);
      chk("rst_valid", vote_valid, 0);
      chk("rst_conflict", vote_conflict, 0);
      chk("rst_index", vote_index, 0);
      chk("rst_busy_en0", busy, 1);
      reset = 1'b0;
      enable = 1'b1;
      #1;
      chk("idle_busy_en1", busy, 0);

      // single press on ch2, held 10 cycles
      clear(); button = 4'b0100;
      run(10); button = 4'b0000;
      run(5);
      chk("single_busy_last_lockout", busy, 1);
      run(1);
      chk("single_busy_idle", busy, 0);
      chk("single_first_valid", fv, 6);
      chk("single_valid_count", nv, 1);
      chk("single_index", last_idx, 2);
      chk("single_index_hold", vote_index, 2);
      chk("single_no_conflict", nc, 0);
      $display("txn single: valid at cycle %0d index %0d", fv, last_idx);

      // bounce on ch1: high 3, low 1, high 10
      clear(); button = 4'b0010;
      run(3); button = 4'b0000;
      run(1); button = 4'b0010;
      chk("bounce_no_early_vote", nv, 0);
      clear();
      run(10); button = 4'b0000;
      run(6);
      chk("bounce_first_valid", fv, 6);
      chk("bounce_valid_count", nv, 1);
      chk("bounce_index", last_idx, 1);
      chk("bounce_busy_idle", busy, 0);
      $display("txn bounce: valid at cycle %0d index %0d", fv, last_idx);

      // conflict: ch0 and ch1 together
      clear(); button = 4'b0011;
      run(10); button = 4'b0000;
      run(6);
      chk("conflict_count", nc, 1);
      chk("conflict_first", fc, 6);
      chk("conflict_no_valid", nv, 0);
      chk("conflict_index_hold", vote_index, 1);
      chk("conflict_busy_idle", busy, 0);
      $display("txn conflict: conflict at cycle %0d", fc);

      // enable gating: ch2 held across rising enable
      enable = 1'b0;
      #1;
      chk("gate_busy_en0", busy, 1);
      clear(); button = 4'b0100;
      run(10); enable = 1'b1;
      run(10);
      chk("gate_no_vote", nv, 0);
      chk("gate_no_conflict", nc, 0);
      button = 4'b0000;
      run(4);
      clear(); button = 4'b0100;
      run(10); button = 4'b0000;
      run(6);
      chk("gate_repress_first", fv, 6);
      chk("gate_repress_count", nv, 1);
      chk("gate_repress_index", last_idx, 2);
      chk("gate_busy_idle", busy, 0);
      $display("txn gate: re-press valid at cycle %0d index %0d", fv, last_idx);

      // lockout discard on the long-lockout instance
      clear(); button_lk = 4'b0001;
      run(8); button_lk = 4'b0000;
      run(4); button_lk = 4'b1000;
      run(6); button_lk = 4'b0000;
      run(2);
      chk("lk_busy_in_lockout", lk_busy, 1);
      run(1);
      chk("lk_busy_idle", lk_busy, 0);
      chk("lk_only_first_vote", lkv, 1);
      chk("lk_first_index", lk_idx, 0);
      chk("lk_no_conflict", lkc, 0);
      chk("lk_main_quiet", nv, 0);
      clear(); button_lk = 4'b1000;
      run(8);
      chk("lk_after_idle_first", lkfv, 6);
      chk("lk_after_idle_count", lkv, 1);
      chk("lk_after_idle_index", lk_idx, 3);
      button_lk = 4'b0000;
      $display("txn lockout: discarded in lockout, later vote index %0d", lk_idx);

      // asynchronous reset mid-LOCKOUT with ch1 held through it
      clear(); button = 4'b0100;
      run(8); button = 4'b0000;
      run(3);
      chk("pre_rst_vote", nv, 1);
      chk("pre_rst_busy", busy, 1);
      button = 4'b0010;
      #2 reset = 1'b1;
      #1;
      chk("arst_index", vote_index, 0);
      chk("arst_busy", busy, 0);
      chk("arst_valid", vote_valid, 0);
      chk("arst_conflict", vote_conflict, 0);
      @(negedge clock);
      reset = 1'b0;
      clear();
      run(8);
      chk("post_rst_first", fv, 6);
      chk("post_rst_count", nv, 1);
      chk("post_rst_index", last_idx, 1);
      button = 4'b0000;
      run(8);
      chk("post_rst_busy_idle", busy, 0);
      $display("txn reset: held button valid at cycle %0d index %0d", fv, last_idx);

      chk("never_both_pulses", nboth, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/vote_button_bank.md
# vote_button_bank

Parametrised multi-channel successor to the single-button vote qualifier. The block synchronises and debounces NUM_CH raw candidate buttons and accepts at most one vote per press, reporting it as a one-cycle pulse with the candidate index. It rejects simultaneous presses as a conflict and enforces a release-then-lockout interval before the next vote. It sits between the panel buttons and the vote tally/control unit.

## Interface
- NUM_CH, 4: number of candidate buttons, ≥2.
- HOLD_CYCLES, 10_000_000: cycles a synchronised button must stay high to qualify, ≥2.
- LOCKOUT_CYCLES, 50_000_000: post-vote dead time after all buttons are released, ≥1.
- IDX_W (localparam), $clog2(NUM_CH): index width.
- clock  in  1  system clock.
- reset  in  1  one clock; reset is asynchronous and active-high.
- enable  in  1  ballot enabled by control unit.
- button  in  NUM_CH  raw asynchronous buttons, active-high.
- vote_valid  out  1  one-cycle pulse: vote accepted.
- vote_index  out  IDX_W  candidate index; valid while vote_valid=1, holds last value otherwise.
- vote_conflict  out  1  one-cycle pulse: press rejected because more than one button was held.
- busy  out  1  high when state≠IDLE or enable=0.

## Operation
- Per channel: 2-flop synchroniser gives s[i]. Counter cnt[i], width $clog2(HOLD_CYCLES+1):
  - If s[i]=0, cnt←0.
  - Else if cnt<HOLD_CYCLES, cnt←cnt+1.
  - Otherwise cnt saturates.
  - qual[i] = s[i] & (cnt[i]==HOLD_CYCLES-1), so each press qualifies at most once.
- FSM states: IDLE, WAIT_RELEASE, LOCKOUT.
  - IDLE, enable=1, qual≠0, exactly one s bit high: vote_valid←1, vote_index←that channel, go to WAIT_RELEASE.
  - IDLE, enable=1, qual≠0, ≥2 s bits high: vote_conflict←1, go to WAIT_RELEASE.
  - IDLE, enable=0: qual is ignored and no outputs are produced. Debounce counters keep running, so a button held across the rising edge of enable never votes until it is released and pressed again.
  - WAIT_RELEASE: stay while any s bit is high. When all s=0, load lock_cnt←LOCKOUT_CYCLES-1 and go to LOCKOUT.
  - LOCKOUT: decrement lock_cnt. At lock_cnt==0, go to IDLE. Presses qualifying here are discarded.
- Changes on enable in WAIT_RELEASE or LOCKOUT do not alter the sequence.
- Reset values: all synchronisers, cnt, lock_cnt, vote_valid, vote_conflict and vote_index are 0; state is IDLE; busy reflects enable.
- Reset mid-operation aborts any state immediately. A button held through reset restarts debouncing from cnt=0.

## Timing
- All outputs are registered. vote_valid and vote_conflict are high for exactly one cycle and are never high together.
- Button first sampled high at edge E0: s=1 after E1, cnt=1 after E2, qual true in the cycle after E_HOLD_CYCLES. vote_valid rises at edge E(HOLD_CYCLES+1), i.e. HOLD_CYCLES+2 sampling edges inclusive.
- Bounce shorter than HOLD_CYCLES (including a single low sample) restarts the count.
- Timing after the last button release:
  - s falls 2 edges after the raw release.
  - LOCKOUT is entered on the next edge.
  - busy stays high for exactly LOCKOUT_CYCLES cycles in LOCKOUT.
  - IDLE is entered on the following edge.
- Simultaneous qualification of two channels in the same cycle counts as a conflict.
- A second button pressed during WAIT_RELEASE extends WAIT_RELEASE only.

## Structure
- Shared package evm_pkg holds the state enum type (vote_state_t: IDLE, WAIT_RELEASE, LOCKOUT) and the default HOLD_CYCLES / LOCKOUT_CYCLES constants.
- One sub-module, button_debounce_ch (synchroniser + saturating counter, outputs s and qual), is instantiated NUM_CH times by generate. The FSM, lockout counter and index encoder live in the top.

## Test plan
Test parameters: NUM_CH=4, HOLD_CYCLES=4, LOCKOUT_CYCLES=3.
- Single press: enable=1, button=4'b0100 held 10 cycles → one vote_valid pulse 6 edges after first sample, vote_index=2, busy=1 until 3 LOCKOUT cycles after s falls.
- Bounce: button[1] high 3 cycles, low 1, high 10 → exactly one vote_valid, index 1, timed from the second rise.
- Conflict: button=4'b0011 raised together → vote_conflict pulse, no vote_valid. Release both → IDLE after lockout.
- Lockout reject: vote on ch0, release, press ch3 for 6 cycles during LOCKOUT → no pulse. Press ch3 again after IDLE → vote_valid with index 3.
- Enable gating: hold ch2 with enable=0, raise enable after 10 cycles → no vote until ch2 is released and re-pressed.
- Async reset: assert reset mid-LOCKOUT, between clock edges → outputs 0 immediately, state IDLE. Held button votes HOLD_CYCLES+2 edges after reset deasserts.
